window_gen_7x7: RTL and testbench
=================================

# window_gen_7x7

Streaming 7x7 window generator: accepts a raster pixel stream one pixel per cycle and emits, for every pixel position whose full 7x7 neighbourhood has been received, the packed 7x7 window together with aligned vsync/hsync/reuse/valid flags. It is the producer side of the windowed interface consumed by the 7x7 convolution MAC and sits between the frame/feature-map reader and the convolution stage. It uses six internal line buffers and a 7x7 register window, with no padding; the output is the "valid" convolution region only.

## Interface

- WIDTH_D, 8, pixel width in bits
- LEN, 7, window size (fixed at 7; other values unsupported)
- IMG_W, 64, maximum line width in pixels; this is also the line-buffer depth
- ROW_W, 16, row counter width

- i_sclk  in  1  clock; all logic is on the rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_vsync  in  1  frame start; qualified by i_valid, coincident with the frame's first pixel
- i_hsync  in  1  line start; qualified by i_valid, coincident with each line's first pixel (the first pixel of a frame carries both flags)
- i_reuse  in  1  per-pixel side flag, passed through
- i_valid  in  1  pixel strobe
- i_tdata  in  WIDTH_D  pixel value
- o_vsync  out  1  first window of a frame
- o_hsync  out  1  first window of an output row
- o_reuse  out  1  i_reuse of the window's bottom-right pixel
- o_valid  out  1  window strobe
- o_tdata  out  WIDTH_D*LEN*LEN  packed window

## Operation

- **Accept rule.** A pixel is accepted when i_valid=1. Flags without i_valid are ignored. There is no backpressure.
- **Effective coordinates of an accepted pixel.**
  - With i_vsync: row=0, col=0.
  - Else with i_hsync: row=row_cnt+1 (saturating at 2^ROW_W-1), col=0.
  - Else: row=row_cnt, col=col_cnt.
  - After acceptance: row_cnt<=row and col_cnt<=col+1. col_cnt saturates at IMG_W.
- **Frame-active flag.** Cleared by reset and set by the first accepted vsync. Pixels accepted while the flag is clear are discarded: no storage, no output.
- **Out-of-range pixels.** Pixels with col>=IMG_W are discarded.
- **Line buffers and window.** Buffers lb0..lb5 are indexed by col. lb0 holds row-6 and lb5 holds row-1.
  - On an accepted pixel, read column col of all buffers to form {lb0..lb5, pixel}, top to bottom.
  - Shift that column into the window as the rightmost column.
  - Write lb[k][col]<=lb[k+1][col] for k=0..4, and lb5[col]<=pixel.
- **Window emission.** A window is emitted when row>=6 and col>=6. The window covers rows row-6..row and cols col-6..col.
- **Packing.** Element c=r*7+k occupies o_tdata[WIDTH_D*(c+1)-1:WIDTH_D*c]. r=0 is the top (oldest) row and k=0 is the leftmost column. Element 48 is the current pixel.
- **Output flags.**
  - o_hsync=1 when col==6.
  - o_vsync=1 when col==6 and row==6.
  - Both are asserted only together with o_valid.
- **Mid-frame vsync.** Counters restart. Stale line-buffer contents are never emitted, because row<6 suppresses output until six new lines have arrived.
- **Reset state.**
  - Line-buffer contents are not reset.
  - Counters, frame-active flag, and window registers reset to 0.

## Timing

- **Latency.** Pixel accepted at cycle t produces its window on o_valid/o_tdata at cycle t+1. Throughput is one window per cycle.
- **Output reset values.** While i_rst_n=0, all outputs are 0, asynchronously: o_vsync, o_hsync, o_reuse, o_valid=0, o_tdata=0.
- **Idle cycles.** On cycles with no emission, o_valid, o_vsync, o_hsync and o_reuse are 0, and o_tdata holds its last value.
- **Gaps.** Gaps in i_valid never change the windows; they only delay them.
- **Reset deasserted mid-frame.** The frame-active flag is clear, so no output is produced until the next vsync.
- **Line-buffer hazards.** Line-buffer read and write of the same column in the same cycle must return the old contents (read-before-write).
- **Line length.** Lines shorter than 7 produce no windows. Line length may vary between lines; windows use the stored columns at the matching col index.

## Test plan

- **Basic 8x8 frame.** IMG_W=8, 8x8 frame, pixel=row*8+col, continuous valid.
  - Exactly 4 windows are produced.
  - First window: o_vsync=o_hsync=1, element0=0, element6=6, element42=48, element48=54.
  - Last window: element48=63, o_vsync=o_hsync=0.
  - Latency is 1 cycle after pixel (6,6).
- **Random gaps.** Same frame with random i_valid gaps (~50%).
  - Windows are identical, 4 o_valid pulses, and o_hsync pulses on windows 1 and 3.
- **Mid-frame vsync.** A new vsync at row 7, col 3, then a full new 8x8 frame with pixel=100+row*8+col.
  - No window before the new pixel (6,6).
  - Its window has element0=100, containing no old-frame data.
- **Reset mid-frame.** i_rst_n low for 2 cycles during row 7.
  - All outputs go to 0 immediately.
  - Continued pixels without vsync produce no windows.
  - After the next vsync frame, normal output resumes.
- **Over-long line.** IMG_W=8, lines of 10 pixels.
  - Pixels at col 8-9 are dropped.
  - Each row>=6 gives exactly 2 windows, and window contents match the 8-column frame.
- **Reuse pass-through.** i_reuse=1 only on pixel (7,7) of the 8x8 frame.
  - o_reuse=1 only on the window with element48=63.

Source files
------------

// File: rtl/window_gen_7x7.sv
// Streaming 7x7 window generator: six column-indexed line buffers feed a 7x7
// shift-register window; a window is emitted for every pixel at row>=6, col>=6.
module window_gen_7x7 #(
  parameter int WIDTH_D = 8,
  parameter int LEN     = 7,
  parameter int IMG_W   = 64,
  parameter int ROW_W   = 16
) (
  input  logic                       i_sclk,
  input  logic                       i_rst_n,
  input  logic                       i_vsync,
  input  logic                       i_hsync,
  input  logic                       i_reuse,
  input  logic                       i_valid,
  input  logic [WIDTH_D-1:0]         i_tdata,
  output logic                       o_vsync,
  output logic                       o_hsync,
  output logic                       o_reuse,
  output logic                       o_valid,
  output logic [WIDTH_D*LEN*LEN-1:0] o_tdata
);

  localparam int COL_W = $clog2(IMG_W + 1);
  localparam int IDX_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int NLB   = LEN - 1;

  localparam logic [COL_W-1:0] COL_LIM   = COL_W'(IMG_W);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(LEN - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(LEN - 1);
  localparam logic [ROW_W-1:0] ROW_MAX   = '1;

  logic               frame_active;
  logic [ROW_W-1:0]   row_cnt;
  logic [COL_W-1:0]   col_cnt;
  logic [ROW_W-1:0]   eff_row;
  logic [COL_W-1:0]   eff_col;
  logic               accept;
  logic               in_range;
  logic               store;
  logic               emit;
  logic [IDX_W-1:0]   lb_idx;

  logic [WIDTH_D-1:0] lb       [NLB][IMG_W];
  logic [WIDTH_D-1:0] col_data [LEN];
  logic [WIDTH_D-1:0] win      [LEN][LEN];
  logic [WIDTH_D-1:0] win_next [LEN][LEN];
  logic [WIDTH_D*LEN*LEN-1:0] win_next_flat;

  // Coordinates this pixel lands on, after applying the frame/line start flags.
  always_comb begin
    eff_row = row_cnt;
    eff_col = col_cnt;
    if (i_vsync) begin
      eff_row = '0;
      eff_col = '0;
    end else if (i_hsync) begin
      eff_row = (row_cnt == ROW_MAX) ? row_cnt : row_cnt + 1'b1;
      eff_col = '0;
    end
  end

  assign accept   = i_valid && (frame_active || i_vsync);
  assign in_range = (eff_col < COL_LIM);
  assign store    = accept && in_range;
  assign emit     = store && (eff_row >= ROW_FIRST) && (eff_col >= COL_FIRST);
  assign lb_idx   = eff_col[IDX_W-1:0];

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_active <= 1'b0;
      row_cnt      <= '0;
      col_cnt      <= '0;
    end else begin
      if (i_valid && i_vsync)
        frame_active <= 1'b1;
      if (accept) begin
        row_cnt <= eff_row;
        col_cnt <= in_range ? eff_col + 1'b1 : COL_LIM;
      end
    end
  end

  // Line buffers are plain storage: no reset, nonblocking writes give read-before-write.
  always_ff @(posedge i_sclk) begin
    if (store) begin
      for (int k = 0; k < NLB - 1; k++)
        lb[k][lb_idx] <= lb[k+1][lb_idx];
      lb[NLB-1][lb_idx] <= i_tdata;
    end
  end

  always_comb begin
    for (int k = 0; k < NLB; k++)
      col_data[k] = lb[k][lb_idx];
    col_data[NLB] = i_tdata;
  end

  // Incoming column enters on the right; element r*LEN+k packs row r, column k.
  always_comb begin
    for (int r = 0; r < LEN; r++) begin
      for (int k = 0; k < LEN - 1; k++)
        win_next[r][k] = win[r][k+1];
      win_next[r][LEN-1] = col_data[r];
    end
    win_next_flat = '0;
    for (int r = 0; r < LEN; r++)
      for (int k = 0; k < LEN; k++)
        win_next_flat[WIDTH_D*(r*LEN+k) +: WIDTH_D] = win_next[r][k];
  end

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < LEN; r++)
        for (int k = 0; k < LEN; k++)
          win[r][k] <= '0;
    end else if (store) begin
      for (int r = 0; r < LEN; r++)
        for (int k = 0; k < LEN; k++)
          win[r][k] <= win_next[r][k];
    end
  end

  // o_tdata only loads on emission so it holds the last window through idle cycles.
  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_vsync <= 1'b0;
      o_hsync <= 1'b0;
      o_reuse <= 1'b0;
      o_tdata <= '0;
    end else begin
      o_valid <= emit;
      o_hsync <= emit && (eff_col == COL_FIRST);
      o_vsync <= emit && (eff_col == COL_FIRST) && (eff_row == ROW_FIRST);
      o_reuse <= emit && i_reuse;
      if (emit)
        o_tdata <= win_next_flat;
    end
  end

endmodule

// File: tb/tb_window_gen_7x7.sv
// Directed bench for window_gen_7x7 with IMG_W=8: frames of pixel=base+row*8+col
// checked against a formula-based window model.
module tb_window_gen_7x7;

  localparam int W  = 8;
  localparam int L  = 7;
  localparam int IW = 8;
  localparam int RW = 16;
  localparam int OW = W * L * L;

  logic          i_sclk = 1'b0;
  logic          i_rst_n;
  logic          i_vsync;
  logic          i_hsync;
  logic          i_reuse;
  logic          i_valid;
  logic [W-1:0]  i_tdata;
  logic          o_vsync;
  logic          o_hsync;
  logic          o_reuse;
  logic          o_valid;
  logic [OW-1:0] o_tdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [OW-1:0] win_q[$];
  bit            vs_q[$];
  bit            hs_q[$];
  bit            ru_q[$];
  int            cyc_q[$];
  int            exp_cyc_q[$];

  window_gen_7x7 #(.WIDTH_D(W), .LEN(L), .IMG_W(IW), .ROW_W(RW)) dut (
    .i_sclk (i_sclk),
    .i_rst_n(i_rst_n),
    .i_vsync(i_vsync),
    .i_hsync(i_hsync),
    .i_reuse(i_reuse),
    .i_valid(i_valid),
    .i_tdata(i_tdata),
    .o_vsync(o_vsync),
    .o_hsync(o_hsync),
    .o_reuse(o_reuse),
    .o_valid(o_valid),
    .o_tdata(o_tdata)
  );

  always #5 i_sclk = ~i_sclk;

  always @(posedge i_sclk) cyc <= cyc + 1;

  // Capture every emitted window; flags must never appear without o_valid.
  always @(negedge i_sclk) begin
    if (o_valid === 1'b1) begin
      win_q.push_back(o_tdata);
      vs_q.push_back(o_vsync);
      hs_q.push_back(o_hsync);
      ru_q.push_back(o_reuse);
      cyc_q.push_back(cyc);
    end else begin
      checks++;
      if ({o_vsync, o_hsync, o_reuse} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL idle_flags: got vs/hs/ru=%b%b%b want 000 at cycle %0d",
                 o_vsync, o_hsync, o_reuse, cyc);
      end
    end
  end

  function automatic logic [OW-1:0] exp_window(input int base, input int row, input int col);
    logic [OW-1:0] w;
    w = '0;
    for (int r = 0; r < L; r++)
      for (int k = 0; k < L; k++)
        w[W*(r*L+k) +: W] = W'(base + (row - 6 + r) * 8 + (col - 6 + k));
    return w;
  endfunction

  task automatic drive(input logic v, input logic vs, input logic hs, input logic ru,
                       input logic [W-1:0] d);
    @(posedge i_sclk);
    #1;
    i_valid = v;
    i_vsync = vs;
    i_hsync = hs;
    i_reuse = ru;
    i_tdata = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                     1'($urandom_range(1, 0)), W'($urandom));
  endtask

  task automatic clear_queues();
    win_q.delete();
    vs_q.delete();
    hs_q.delete();
    ru_q.delete();
    cyc_q.delete();
    exp_cyc_q.delete();
  endtask

  // Rows r0..nrows-1; first row starts at c0, last row has last_cols pixels.
  task automatic send_frame(input int base, input int ncols, input int nrows, input int last_cols,
                            input bit with_vs, input int r0, input int c0, input bit gaps,
                            input bit record);
    for (int r = r0; r < nrows; r++) begin
      int cs;
      int ce;
      cs = (r == r0) ? c0 : 0;
      ce = (r == nrows - 1) ? last_cols : ncols;
      for (int c = cs; c < ce; c++) begin
        if (gaps)
          for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++) idle(1);
        drive(1'b1, with_vs && r == r0 && c == c0, c == 0, r == 7 && c == 7, W'(base + r * 8 + c));
        if (record && r >= 6 && c >= 6 && c < IW) exp_cyc_q.push_back(cyc + 1);
      end
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_vsync = 1'b0;
    i_hsync = 1'b0;
    i_reuse = 1'b0;
    i_tdata = '0;
    repeat (3) @(posedge i_sclk);
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", o_valid); end
    checks++; if (o_vsync !== 1'b0) begin errors++; $display("[TB] FAIL reset_vsync: got %b want 0", o_vsync); end
    checks++; if (o_hsync !== 1'b0) begin errors++; $display("[TB] FAIL reset_hsync: got %b want 0", o_hsync); end
    checks++; if (o_reuse !== 1'b0) begin errors++; $display("[TB] FAIL reset_reuse: got %b want 0", o_reuse); end
    checks++; if (o_tdata !== '0) begin errors++; $display("[TB] FAIL reset_tdata: got %h want 0", o_tdata); end
    i_rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic_frame();
    clear_queues();
    send_frame(0, 8, 8, 8, 1'b1, 0, 0, 1'b0, 1'b1);
    idle(3);
    checks++;
    if (win_q.size() != 4) begin errors++; $display("[TB] FAIL basic_count: got %0d windows want 4", win_q.size()); end
    if (win_q.size() > 0) begin
      checks++; if (win_q[0][0 +: W] !== 8'd0) begin errors++; $display("[TB] FAIL basic_e0: got %0d want 0", win_q[0][0 +: W]); end
      checks++; if (win_q[0][6*W +: W] !== 8'd6) begin errors++; $display("[TB] FAIL basic_e6: got %0d want 6", win_q[0][6*W +: W]); end
      checks++; if (win_q[0][42*W +: W] !== 8'd48) begin errors++; $display("[TB] FAIL basic_e42: got %0d want 48", win_q[0][42*W +: W]); end
      checks++; if (win_q[0][48*W +: W] !== 8'd54) begin errors++; $display("[TB] FAIL basic_e48: got %0d want 54", win_q[0][48*W +: W]); end
    end
    for (int i = 0; i < win_q.size() && i < 4; i++) begin
      logic [OW-1:0] ew;
      int ec;
      ew = exp_window(0, 6 + i / 2, 6 + i % 2);
      ec = (i < exp_cyc_q.size()) ? exp_cyc_q[i] : -1;
      checks++; if (win_q[i] !== ew) begin errors++; $display("[TB] FAIL basic_win%0d: got %h want %h", i, win_q[i], ew); end
      checks++; if (vs_q[i] !== (i == 0)) begin errors++; $display("[TB] FAIL basic_vs%0d: got %b want %b", i, vs_q[i], i == 0); end
      checks++; if (hs_q[i] !== (i % 2 == 0)) begin errors++; $display("[TB] FAIL basic_hs%0d: got %b want %b", i, hs_q[i], i % 2 == 0); end
      checks++; if (ru_q[i] !== (i == 3)) begin errors++; $display("[TB] FAIL basic_reuse%0d: got %b want %b", i, ru_q[i], i == 3); end
      checks++; if (cyc_q[i] != ec) begin errors++; $display("[TB] FAIL basic_latency%0d: got cycle %0d want %0d", i, cyc_q[i], ec); end
    end
    checks++;
    if (o_tdata !== exp_window(0, 7, 7)) begin errors++; $display("[TB] FAIL basic_hold: got %h want %h", o_tdata, exp_window(0, 7, 7)); end
  endtask

  task automatic test_random_gaps();
    clear_queues();
    send_frame(0, 8, 8, 8, 1'b1, 0, 0, 1'b1, 1'b1);
    idle(3);
    checks++;
    if (win_q.size() != 4) begin errors++; $display("[TB] FAIL gaps_count: got %0d windows want 4", win_q.size()); end
    for (int i = 0; i < win_q.size() && i < 4; i++) begin
      logic [OW-1:0] ew;
      int ec;
      ew = exp_window(0, 6 + i / 2, 6 + i % 2);
      ec = (i < exp_cyc_q.size()) ? exp_cyc_q[i] : -1;
      checks++; if (win_q[i] !== ew) begin errors++; $display("[TB] FAIL gaps_win%0d: got %h want %h", i, win_q[i], ew); end
      checks++; if (hs_q[i] !== (i % 2 == 0)) begin errors++; $display("[TB] FAIL gaps_hs%0d: got %b want %b", i, hs_q[i], i % 2 == 0); end
      checks++; if (vs_q[i] !== (i == 0)) begin errors++; $display("[TB] FAIL gaps_vs%0d: got %b want %b", i, vs_q[i], i == 0); end
      checks++; if (cyc_q[i] != ec) begin errors++; $display("[TB] FAIL gaps_latency%0d: got cycle %0d want %0d", i, cyc_q[i], ec); end
    end
  endtask

  task automatic test_mid_vsync();
    send_frame(0, 8, 8, 3, 1'b1, 0, 0, 1'b0, 1'b0);
    clear_queues();
    send_frame(100, 8, 8, 8, 1'b1, 0, 0, 1'b0, 1'b1);
    idle(3);
    checks++;
    if (win_q.size() != 4) begin errors++; $display("[TB] FAIL midvs_count: got %0d windows want 4", win_q.size()); end
    if (win_q.size() > 0) begin
      checks++; if (win_q[0][0 +: W] !== 8'd100) begin errors++; $display("[TB] FAIL midvs_e0: got %0d want 100", win_q[0][0 +: W]); end
    end
    for (int i = 0; i < win_q.size() && i < 4; i++) begin
      logic [OW-1:0] ew;
      int ec;
      ew = exp_window(100, 6 + i / 2, 6 + i % 2);
      ec = (i < exp_cyc_q.size()) ? exp_cyc_q[i] : -1;
      checks++; if (win_q[i] !== ew) begin errors++; $display("[TB] FAIL midvs_win%0d: got %h want %h", i, win_q[i], ew); end
      checks++; if (cyc_q[i] != ec) begin errors++; $display("[TB] FAIL midvs_latency%0d: got cycle %0d want %0d", i, cyc_q[i], ec); end
      checks++; if (vs_q[i] !== (i == 0)) begin errors++; $display("[TB] FAIL midvs_vs%0d: got %b want %b", i, vs_q[i], i == 0); end
    end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(0, 8, 8, 4, 1'b1, 0, 0, 1'b0, 1'b0);
    @(posedge i_sclk);
    #1;
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_tdata !== '0) begin errors++; $display("[TB] FAIL rstmid_tdata: got %h want 0", o_tdata); end
    checks++; if ({o_valid, o_vsync, o_hsync, o_reuse} !== 4'b0000) begin errors++; $display("[TB] FAIL rstmid_flags: got %b want 0000", {o_valid, o_vsync, o_hsync, o_reuse}); end
    repeat (2) @(posedge i_sclk);
    #1;
    i_rst_n = 1'b1;
    clear_queues();
    send_frame(0, 8, 15, 8, 1'b0, 7, 4, 1'b0, 1'b0);
    idle(3);
    checks++;
    if (win_q.size() != 0) begin errors++; $display("[TB] FAIL rstmid_novsync: got %0d windows want 0", win_q.size()); end
    clear_queues();
    send_frame(0, 8, 8, 8, 1'b1, 0, 0, 1'b0, 1'b1);
    idle(3);
    checks++;
    if (win_q.size() != 4) begin errors++; $display("[TB] FAIL rstmid_count: got %0d windows want 4", win_q.size()); end
    for (int i = 0; i < win_q.size() && i < 4; i++) begin
      logic [OW-1:0] ew;
      int ec;
      ew = exp_window(0, 6 + i / 2, 6 + i % 2);
      ec = (i < exp_cyc_q.size()) ? exp_cyc_q[i] : -1;
      checks++; if (win_q[i] !== ew) begin errors++; $display("[TB] FAIL rstmid_win%0d: got %h want %h", i, win_q[i], ew); end
      checks++; if (cyc_q[i] != ec) begin errors++; $display("[TB] FAIL rstmid_latency%0d: got cycle %0d want %0d", i, cyc_q[i], ec); end
    end
  endtask

  task automatic test_long_line();
    clear_queues();
    send_frame(0, 10, 8, 10, 1'b1, 0, 0, 1'b0, 1'b1);
    idle(3);
    checks++;
    if (win_q.size() != 4) begin errors++; $display("[TB] FAIL long_count: got %0d windows want 4", win_q.size()); end
    for (int i = 0; i < win_q.size() && i < 4; i++) begin
      logic [OW-1:0] ew;
      int ec;
      ew = exp_window(0, 6 + i / 2, 6 + i % 2);
      ec = (i < exp_cyc_q.size()) ? exp_cyc_q[i] : -1;
      checks++; if (win_q[i] !== ew) begin errors++; $display("[TB] FAIL long_win%0d: got %h want %h", i, win_q[i], ew); end
      checks++; if (hs_q[i] !== (i % 2 == 0)) begin errors++; $display("[TB] FAIL long_hs%0d: got %b want %b", i, hs_q[i], i % 2 == 0); end
      checks++; if (ru_q[i] !== (i == 3)) begin errors++; $display("[TB] FAIL long_reuse%0d: got %b want %b", i, ru_q[i], i == 3); end
      checks++; if (cyc_q[i] != ec) begin errors++; $display("[TB] FAIL long_latency%0d: got cycle %0d want %0d", i, cyc_q[i], ec); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_random_gaps();
    test_mid_vsync();
    test_reset_mid_frame();
    test_long_line();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL timeout: got no completion by %0t want completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
